tiger_mem_arbiter: RTL and testbench

//  Shares one Avalon-MM burst master between two Tiger cache masters: port 0 = instruction

---
 rtl/tiger_arb_pkg.sv | 18 +
 rtl/tiger_arb_pick.sv | 36 +++
 rtl/tiger_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_tiger_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiger_arb_pkg.sv
// Shared definitions for the Tiger memory arbiter: FSM encoding, port indices
// and default widths.
package tiger_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DATA  = 2'd2
   } arb_state_e;

   localparam int PORT_ICACHE = 0;
   localparam int PORT_DCACHE = 1;

   localparam int ARB_ADDR_W  = 32;
   localparam int ARB_DATA_W  = 32;
   localparam int ARB_BURST_W = 3;

endpackage

// File: rtl/tiger_arb_pick.sv
// Two-way grant picker for the Tiger memory arbiter. Purely combinational;
// the last-owner flop lives in the parent.
// TIGER_ARB_RR_EN defined  : round-robin, last owner loses a tie.
// TIGER_ARB_RR_EN undefined: fixed priority, dcache wins every tie.
module tiger_arb_pick
   import tiger_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic [1:0] grant
);

`ifdef TIGER_ARB_RR_EN
   // tie goes to whichever port did not own the bus last
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last_owner ? 2'b01 : 2'b10;
      end
   end
`else
   logic unused_last_owner;
   assign unused_last_owner = last_owner;

   // dcache first, icache only when dcache is quiet
   always_comb begin
      grant = 2'b00;
      if (req[PORT_DCACHE]) begin
         grant[PORT_DCACHE] = 1'b1;
      end else if (req[PORT_ICACHE]) begin
         grant[PORT_ICACHE] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/tiger_mem_arbiter.sv
// Tiger memory arbiter: shares one Avalon-MM burst master between the icache
// (port 0) and dcache (port 1), one read burst or single write at a time.
// Arbitration mode selected by macro TIGER_ARB_RR_EN (see tiger_arb_pick).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; next request is captured and its port owns the bus
// ISSUE | registered request driven downstream until avm_waitrequest drops
// DATA  | read accepted; forwarding beats to the owner until the count expires
module tiger_mem_arbiter
   import tiger_arb_pkg::*;
#(
   parameter int ADDR_W  = ARB_ADDR_W,
   parameter int DATA_W  = ARB_DATA_W,
   parameter int BURST_W = ARB_BURST_W
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [1:0]              req_read,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_W-1:0]     req_address,
   input  logic [2*DATA_W-1:0]     req_writedata,
   input  logic [2*DATA_W/8-1:0]   req_byteenable,
   input  logic [2*BURST_W-1:0]    req_burstcount,
   output logic [1:0]              req_waitrequest,
   output logic [DATA_W-1:0]       req_readdata,
   output logic [1:0]              req_readdatavalid,
   output logic                    avm_read,
   output logic                    avm_write,
   output logic [ADDR_W-1:0]       avm_address,
   output logic [DATA_W-1:0]       avm_writedata,
   output logic [DATA_W/8-1:0]     avm_byteenable,
   output logic [BURST_W-1:0]      avm_burstcount,
   output logic                    avm_beginbursttransfer,
   input  logic                    avm_waitrequest,
   input  logic [DATA_W-1:0]       avm_readdata,
   input  logic                    avm_readdatavalid
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [BURST_W-1:0] ONE_BEAT = BURST_W'(1);

   arb_state_e          state_q, state_d;
   logic                owner_q, owner_d;
   logic [BURST_W-1:0]  beats_q, beats_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic                bbt_q, bbt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [BURST_W-1:0]  bc_q, bc_d;

   logic [1:0]          grant;
   logic                pick;
   logic                sel_read, sel_write;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [BE_W-1:0]     sel_be;
   logic [BURST_W-1:0]  sel_bc;

   tiger_arb_pick u_pick (
      .req        (req_read | req_write),
      .last_owner (owner_q),
      .grant      (grant)
   );

   assign pick      = grant[PORT_DCACHE];
   assign sel_read  = req_read[pick];
   assign sel_write = req_write[pick];
   assign sel_addr  = pick ? req_address[ADDR_W +: ADDR_W]     : req_address[0 +: ADDR_W];
   assign sel_wdata = pick ? req_writedata[DATA_W +: DATA_W]   : req_writedata[0 +: DATA_W];
   assign sel_be    = pick ? req_byteenable[BE_W +: BE_W]      : req_byteenable[0 +: BE_W];
   assign sel_bc    = pick ? req_burstcount[BURST_W +: BURST_W] : req_burstcount[0 +: BURST_W];

   // next-state, downstream capture and per-port response routing
   always_comb begin
      state_d           = state_q;
      owner_d           = owner_q;
      beats_d           = beats_q;
      rd_d              = rd_q;
      wr_d              = wr_q;
      bbt_d             = 1'b0;
      addr_d            = addr_q;
      wdata_d           = wdata_q;
      be_d              = be_q;
      bc_d              = bc_q;
      req_waitrequest   = 2'b11;
      req_readdatavalid = 2'b00;

      case (state_q)
         ST_IDLE: begin
            if (|grant) begin
               state_d = ST_ISSUE;
               owner_d = pick;
               // read wins when a port raises both strobes
               rd_d    = sel_read;
               wr_d    = sel_write & ~sel_read;
               bbt_d   = sel_read;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               be_d    = sel_be;
               // a zero-length read is issued downstream as a single beat
               bc_d    = (sel_read && sel_bc != '0) ? sel_bc : ONE_BEAT;
            end
         end

         ST_ISSUE: begin
            req_waitrequest[owner_q] = avm_waitrequest;
            if (!avm_waitrequest) begin
               rd_d = 1'b0;
               wr_d = 1'b0;
               if (rd_q) begin
                  beats_d = bc_q;
                  state_d = ST_DATA;
                  // slave may return the first beat in the same cycle it accepts
                  if (avm_readdatavalid) begin
                     req_readdatavalid[owner_q] = 1'b1;
                     beats_d = bc_q - ONE_BEAT;
                     if (bc_q == ONE_BEAT) begin
                        state_d = ST_IDLE;
                     end
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_DATA: begin
            if (avm_readdatavalid) begin
               req_readdatavalid[owner_q] = 1'b1;
               beats_d = beats_q - ONE_BEAT;
               if (beats_q == ONE_BEAT) begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // state, owner and downstream request registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         beats_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         bbt_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         bc_q    <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         beats_q <= beats_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         bbt_q   <= bbt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         bc_q    <= bc_d;
      end
   end

   assign avm_read               = rd_q;
   assign avm_write              = wr_q;
   assign avm_beginbursttransfer = bbt_q;
   assign avm_address            = addr_q;
   assign avm_writedata          = wdata_q;
   assign avm_byteenable         = be_q;
   assign avm_burstcount         = bc_q;
   assign req_readdata           = avm_readdata;

endmodule

// File: tb/tb_tiger_mem_arbiter.sv
// Directed bench for tiger_mem_arbiter with a read-beat scoreboard.
module tb_tiger_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  req_read, req_write;
   logic [63:0] req_address, req_writedata;
   logic [7:0]  req_byteenable;
   logic [5:0]  req_burstcount;
   logic [1:0]  req_waitrequest, req_readdatavalid;
   logic [31:0] req_readdata;
   logic        avm_read, avm_write, avm_beginbursttransfer;
   logic [31:0] avm_address, avm_writedata, avm_readdata;
   logic [3:0]  avm_byteenable;
   logic [2:0]  avm_burstcount;
   logic        avm_waitrequest, avm_readdatavalid;

   typedef struct packed {
      logic        port;
      logic [31:0] data;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    failures = 0;
   int    pushed = 0;
   int    seen = 0;
   logic  last_owner = 1'b0;
   logic  g;

   always #5 clk = ~clk;

   tiger_mem_arbiter dut (
      .clk                    (clk),
      .reset_n                (reset_n),
      .req_read               (req_read),
      .req_write              (req_write),
      .req_address            (req_address),
      .req_writedata          (req_writedata),
      .req_byteenable         (req_byteenable),
      .req_burstcount         (req_burstcount),
      .req_waitrequest        (req_waitrequest),
      .req_readdata           (req_readdata),
      .req_readdatavalid      (req_readdatavalid),
      .avm_read               (avm_read),
      .avm_write              (avm_write),
      .avm_address            (avm_address),
      .avm_writedata          (avm_writedata),
      .avm_byteenable         (avm_byteenable),
      .avm_burstcount         (avm_burstcount),
      .avm_beginbursttransfer (avm_beginbursttransfer),
      .avm_waitrequest        (avm_waitrequest),
      .avm_readdata           (avm_readdata),
      .avm_readdatavalid      (avm_readdatavalid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input logic [2:0] bc);
      req_read[p]              = rd;
      req_write[p]             = wr;
      req_address[p*32 +: 32]  = a;
      req_writedata[p*32 +: 32] = d;
      req_byteenable[p*4 +: 4] = be;
      req_burstcount[p*3 +: 3] = bc;
   endtask

   task automatic clr_req();
      req_read       = '0;
      req_write      = '0;
      req_address    = '0;
      req_writedata  = '0;
      req_byteenable = '0;
      req_burstcount = '0;
   endtask

   // one slave beat for the cycle starting now; the expected owner/data go to the scoreboard
   task automatic beat(input logic p, input logic [31:0] d);
      beat_t e;
      e.port = p;
      e.data = d;
      exp_q.push_back(e);
      pushed++;
      avm_readdatavalid = 1'b1;
      avm_readdata      = d;
      @(negedge clk);
      tick();
      avm_readdatavalid = 1'b0;
   endtask

   // scoreboard: every forwarded beat must match the oldest expected beat
   always @(negedge clk) begin
      if (reset_n === 1'b1 && req_readdatavalid !== 2'b00) begin
         beat_t e;
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_unexpected observed=%0h expected=%0h", req_readdatavalid, 2'b00);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            seen++;
            chk("sb_port", req_readdatavalid, e.port ? 2'b10 : 2'b01);
            chk("sb_data", req_readdata, e.data);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      clr_req();
      avm_waitrequest   = 1'b0;
      avm_readdata      = '0;
      avm_readdatavalid = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_read",  avm_read, 0);
      chk("rst_write", avm_write, 0);
      chk("rst_bbt",   avm_beginbursttransfer, 0);
      chk("rst_addr",  avm_address, 0);
      chk("rst_wdata", avm_writedata, 0);
      chk("rst_be",    avm_byteenable, 0);
      chk("rst_bc",    avm_burstcount, 0);
      chk("rst_wreq",  req_waitrequest, 2'b11);
      chk("rst_rdv",   req_readdatavalid, 2'b00);
      tick();
      reset_n = 1'b1;
      tick();

      // 1: icache burst read of 4 beats
      set_req(0, 1, 0, 32'h100, 0, 4'hF, 3'd4);
      @(negedge clk);
      chk("t1_read_early", avm_read, 0);
      tick();
      @(negedge clk);
      chk("t1_read", avm_read, 1);
      chk("t1_addr", avm_address, 32'h100);
      chk("t1_bc",   avm_burstcount, 4);
      chk("t1_bbt",  avm_beginbursttransfer, 1);
      chk("t1_wreq", req_waitrequest, 2'b10);
      tick();
      clr_req();
      @(negedge clk);
      chk("t1_read_drop", avm_read, 0);
      chk("t1_bbt_drop",  avm_beginbursttransfer, 0);
      chk("t1_wreq_data", req_waitrequest, 2'b11);
      tick();
      for (int i = 0; i < 4; i++) beat(1'b0, 32'hA0 + i);
      avm_readdatavalid = 1'b1;
      @(negedge clk);
      chk("t1_stray_idle", req_readdatavalid, 2'b00);
      tick();
      avm_readdatavalid = 1'b0;
      chk("t1_sb_empty", exp_q.size(), 0);

      // 3: simultaneous single-beat reads, four rounds
      last_owner = 1'b0;
      for (int k = 0; k < 4; k++) begin
`ifdef TIGER_ARB_RR_EN
         g = ~last_owner;
`else
         g = 1'b1;
`endif
         last_owner = g;
         set_req(0, 1, 0, 32'h300 + k * 16, 0, 4'hF, 3'd1);
         set_req(1, 1, 0, 32'h400 + k * 16, 0, 4'hF, 3'd1);
         tick();
         @(negedge clk);
         chk("t3_grant", req_waitrequest, g ? 2'b01 : 2'b10);
         chk("t3_addr",  avm_address, g ? (32'h400 + k * 16) : (32'h300 + k * 16));
         tick();
         clr_req();
         beat(g, 32'hC0 + k);
      end

      // 2: dcache write stalled 3 cycles downstream
      avm_waitrequest = 1'b1;
      set_req(1, 0, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 3'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_wreq_stall", req_waitrequest, 2'b11);
         chk("t2_write", avm_write, 1);
         if (i == 0) begin
            chk("t2_addr",  avm_address, 32'h2000);
            chk("t2_wdata", avm_writedata, 32'hDEADBEEF);
            chk("t2_be",    avm_byteenable, 4'hF);
            chk("t2_bc",    avm_burstcount, 1);
            chk("t2_read",  avm_read, 0);
         end
         tick();
      end
      avm_waitrequest = 1'b0;
      @(negedge clk);
      chk("t2_wreq_accept", req_waitrequest, 2'b01);
      tick();
      clr_req();
      @(negedge clk);
      chk("t2_write_drop", avm_write, 0);
      chk("t2_wreq_idle",  req_waitrequest, 2'b11);
      tick();

      // 4: burstcount 0 behaves as one beat, then stray beat is dropped
      set_req(0, 1, 0, 32'h500, 0, 4'hF, 3'd0);
      tick();
      @(negedge clk);
      chk("t4_read", avm_read, 1);
      tick();
      clr_req();
      beat(1'b0, 32'hE0);
      avm_readdatavalid = 1'b1;
      @(negedge clk);
      chk("t4_stray_idle", req_readdatavalid, 2'b00);
      tick();
      avm_readdatavalid = 1'b0;

      // 4b: first beat arrives in the acceptance cycle
      set_req(1, 1, 0, 32'h580, 0, 4'hF, 3'd2);
      tick();
      beat(1'b1, 32'hF0);
      clr_req();
      beat(1'b1, 32'hF1);
      avm_readdatavalid = 1'b1;
      @(negedge clk);
      chk("t4b_stray_idle", req_readdatavalid, 2'b00);
      tick();
      avm_readdatavalid = 1'b0;

      // 5: reset after beat 2 of a 4-beat burst
      set_req(0, 1, 0, 32'h600, 0, 4'hF, 3'd4);
      tick();
      tick();
      clr_req();
      beat(1'b0, 32'h61);
      beat(1'b0, 32'h62);
      #2;
      reset_n = 1'b0;
      avm_readdatavalid = 1'b1;
      #1;
      chk("t5_rst_read", avm_read, 0);
      chk("t5_rst_addr", avm_address, 0);
      chk("t5_rst_bc",   avm_burstcount, 0);
      chk("t5_rst_wreq", req_waitrequest, 2'b11);
      chk("t5_rst_rdv",  req_readdatavalid, 2'b00);
      avm_readdatavalid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      set_req(1, 1, 0, 32'h700, 0, 4'hF, 3'd1);
      @(negedge clk);
      chk("t5_read_early", avm_read, 0);
      tick();
      @(negedge clk);
      chk("t5_read", avm_read, 1);
      chk("t5_addr", avm_address, 32'h700);
      chk("t5_wreq", req_waitrequest, 2'b01);
      tick();
      clr_req();
      beat(1'b1, 32'h77);
      tick();

      chk("end_sb_empty", exp_q.size(), 0);
      chk("end_beats", seen, pushed);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
